// File: rtl/sensor_gpio_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sensor_gpio_pkg                                                       |
// | Shared defaults, per-channel config record and status update helper.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package sensor_gpio_pkg;

    localparam int N_CH_DEFAULT = 6;
    localparam int DB_W_DEFAULT = 16;

    typedef struct packed {
        logic dir;
        logic out;
        logic rise_en;
        logic fall_en;
    } gpio_ch_cfg_t;

    // A new edge outranks a clear arriving in the same cycle.
    function automatic logic irq_next(
        input logic         status,
        input logic         clr,
        input logic         rise,
        input logic         fall,
        input gpio_ch_cfg_t cfg
    );
        return (status & ~clr) | (rise & cfg.rise_en) | (fall & cfg.fall_en);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_debounce_ch.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | gpio_debounce_ch                                                      |
// | One channel: 2-flop synchroniser, debounce counter, rise/fall pulses. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module gpio_debounce_ch #(
    parameter int DB_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_pin,
    input  logic [DB_W-1:0] i_cfg_db,
    output logic            o_pin_state,
    output logic            o_rise,
    output logic            o_fall
);

    logic            r_sync1;
    logic            r_sync2;
    logic [DB_W-1:0] r_cnt;
    logic            r_pin_state;
    logic            r_pin_prev;
    logic [DB_W-1:0] w_db_last;
    logic            w_differ;

    assign w_db_last = i_cfg_db - DB_W'(1);
    assign w_differ  = r_sync2 != r_pin_state;

    // r_cnt stays below cfg_db-1 before incrementing, so it cannot wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_cnt       <= '0;
            r_pin_state <= 1'b0;
            r_pin_prev  <= 1'b0;
        end else begin
            r_sync1    <= i_pin;
            r_sync2    <= r_sync1;
            r_pin_prev <= r_pin_state;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (i_cfg_db == '0) begin
                r_pin_state <= r_sync2;
                r_cnt       <= '0;
            end else if (r_cnt >= w_db_last) begin
                r_pin_state <= r_sync2;
                r_cnt       <= '0;
            end else begin
                r_cnt <= r_cnt + DB_W'(1);
            end
        end
    end

    assign o_pin_state = r_pin_state;
    assign o_rise      = r_pin_state & ~r_pin_prev;
    assign o_fall      = ~r_pin_state & r_pin_prev;

endmodule
`default_nettype wire

// File: rtl/sensor_gpio_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sensor_gpio_ctrl                                                      |
// | N-channel tristate GPIO with debounce and sticky edge interrupts.     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module sensor_gpio_ctrl
    import sensor_gpio_pkg::*;
#(
    parameter int N_CH = N_CH_DEFAULT,
    parameter int DB_W = DB_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] gpio_i,
    output logic [N_CH-1:0] gpio_o,
    output logic [N_CH-1:0] gpio_t,
    input  logic [N_CH-1:0] cfg_dir,
    input  logic [N_CH-1:0] cfg_out,
    input  logic [DB_W-1:0] cfg_db,
    input  logic [N_CH-1:0] cfg_rise_en,
    input  logic [N_CH-1:0] cfg_fall_en,
    input  logic [N_CH-1:0] irq_clr,
    output logic [N_CH-1:0] pin_state,
    output logic [N_CH-1:0] irq_status,
    output logic            irq
);

    gpio_ch_cfg_t    w_cfg [N_CH];
    logic [N_CH-1:0] w_rise;
    logic [N_CH-1:0] w_fall;
    logic [N_CH-1:0] w_pin_state;
    logic [N_CH-1:0] w_t_next;
    logic [N_CH-1:0] w_o_next;
    logic [N_CH-1:0] w_irq_next;

    logic [N_CH-1:0] r_gpio_t;
    logic [N_CH-1:0] r_gpio_o;
    logic [N_CH-1:0] r_irq_status;

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_ch
            assign w_cfg[g] = '{
                dir:     cfg_dir[g],
                out:     cfg_out[g],
                rise_en: cfg_rise_en[g],
                fall_en: cfg_fall_en[g]
            };

            gpio_debounce_ch #(
                .DB_W(DB_W)
            ) u_db (
                .clk         (clk),
                .rst         (rst),
                .i_pin       (gpio_i[g]),
                .i_cfg_db    (cfg_db),
                .o_pin_state (w_pin_state[g]),
                .o_rise      (w_rise[g]),
                .o_fall      (w_fall[g])
            );

            assign w_t_next[g]   = ~w_cfg[g].dir;
            assign w_o_next[g]   = w_cfg[g].out;
            assign w_irq_next[g] = irq_next(r_irq_status[g], irq_clr[g],
                                            w_rise[g], w_fall[g], w_cfg[g]);
        end
    endgenerate

    // All pins come out of reset as inputs so nothing drives the header.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gpio_t     <= '1;
            r_gpio_o     <= '0;
            r_irq_status <= '0;
        end else begin
            r_gpio_t     <= w_t_next;
            r_gpio_o     <= w_o_next;
            r_irq_status <= w_irq_next;
        end
    end

    assign gpio_t     = r_gpio_t;
    assign gpio_o     = r_gpio_o;
    assign pin_state  = w_pin_state;
    assign irq_status = r_irq_status;
    assign irq        = |r_irq_status;

endmodule
`default_nettype wire

// File: tb/tb_sensor_gpio_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_sensor_gpio_ctrl                                                   |
// | Directed and random checks of sensor_gpio_ctrl against a run-length   |
// | reference model. Revision: 1.0                                        |
// +-----------------------------------------------------------------------+
module tb_sensor_gpio_ctrl;

    localparam int c_N  = 6;
    localparam int c_N2 = 32;
    localparam int c_DW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [c_N-1:0]  gpio_i, cfg_dir, cfg_out, cfg_rise_en, cfg_fall_en, irq_clr;
    logic [c_DW-1:0] cfg_db;
    logic [c_N-1:0]  gpio_o, gpio_t, pin_state, irq_status;
    logic            irq;

    logic [c_N2-1:0] g32_in;
    logic [c_N2-1:0] g32_o, g32_t, g32_pin, g32_irqs;
    logic            g32_irq;

    int n_total = 0;
    int n_bad   = 0;

    // reference model state
    logic [c_N-1:0] m_s1, m_s2, m_pin, m_prev, m_irq, m_gt, m_go;
    int             m_run [c_N];

    always #5 clk = ~clk;

    sensor_gpio_ctrl #(.N_CH(c_N), .DB_W(c_DW)) u_dut (
        .clk(clk), .rst(rst), .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_t(gpio_t),
        .cfg_dir(cfg_dir), .cfg_out(cfg_out), .cfg_db(cfg_db),
        .cfg_rise_en(cfg_rise_en), .cfg_fall_en(cfg_fall_en), .irq_clr(irq_clr),
        .pin_state(pin_state), .irq_status(irq_status), .irq(irq)
    );

    sensor_gpio_ctrl #(.N_CH(c_N2), .DB_W(c_DW)) u_dut32 (
        .clk(clk), .rst(rst), .gpio_i(g32_in), .gpio_o(g32_o), .gpio_t(g32_t),
        .cfg_dir('0), .cfg_out('0), .cfg_db('0),
        .cfg_rise_en('0), .cfg_fall_en('0), .irq_clr('0),
        .pin_state(g32_pin), .irq_status(g32_irqs), .irq(g32_irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A pin's level is accepted once it has differed from the debounced
    // level for cfg_db consecutive synchronised cycles (immediately if 0).
    task automatic model_edge();
        logic [c_N-1:0] n_irq;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_pin = '0; m_prev = '0; m_irq = '0;
            m_gt = '1; m_go = '0;
            for (int i = 0; i < c_N; i++) m_run[i] = 0;
        end else begin
            n_irq = (m_irq & ~irq_clr) | (m_pin & ~m_prev & cfg_rise_en)
                  | (~m_pin & m_prev & cfg_fall_en);
            m_prev = m_pin;
            for (int i = 0; i < c_N; i++) begin
                if (m_s2[i] == m_pin[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i] = m_run[i] + 1;
                    if (cfg_db == 0 || m_run[i] >= int'(cfg_db)) begin
                        m_pin[i] = m_s2[i];
                        m_run[i] = 0;
                    end
                end
            end
            m_irq = n_irq;
            m_s2  = m_s1;
            m_s1  = gpio_i;
            m_gt  = ~cfg_dir;
            m_go  = cfg_out;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("gpio_t", 32'(gpio_t), 32'(m_gt));
        chk("gpio_o", 32'(gpio_o), 32'(m_go));
        chk("pin_state", 32'(pin_state), 32'(m_pin));
        chk("irq_status", 32'(irq_status), 32'(m_irq));
        chk("irq", 32'(irq), 32'(|m_irq));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; gpio_i = '0; cfg_dir = '0; cfg_out = '0; cfg_db = '0;
        cfg_rise_en = '0; cfg_fall_en = '0; irq_clr = '0; g32_in = '0;

        // reset state
        steps(3);
        chk("rst_gpio_t", 32'(gpio_t), 32'h3F);
        chk("rst_gpio_o", 32'(gpio_o), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rst = 1'b0;
        steps(3);
        chk("idle_pin", 32'(pin_state), 32'h0);
        chk("idle_irq", 32'(irq), 32'h0);

        // output path
        cfg_dir = 6'h05; cfg_out = 6'h01;
        step();
        chk("dir_gpio_t", 32'(gpio_t), 32'h3A);
        chk("dir_gpio_o", 32'(gpio_o), 32'h01);

        // debounced rise with D=4
        cfg_db = 16'd4; cfg_rise_en = 6'b000100;
        step();
        gpio_i[2] = 1'b1;
        steps(5);
        chk("rise_c5_pin", 32'(pin_state[2]), 32'h0);
        step();
        chk("rise_c6_pin", 32'(pin_state[2]), 32'h1);
        chk("rise_c6_irqs", 32'(irq_status[2]), 32'h0);
        step();
        chk("rise_c7_irqs", 32'(irq_status[2]), 32'h1);
        chk("rise_c7_irq", 32'(irq), 32'h1);

        // 3-cycle glitch is rejected
        cfg_rise_en[3] = 1'b1;
        gpio_i[3] = 1'b1;
        steps(3);
        gpio_i[3] = 1'b0;
        steps(8);
        chk("glitch_pin", 32'(pin_state[3]), 32'h0);
        chk("glitch_irqs", 32'(irq_status[3]), 32'h0);

        // set wins over simultaneous clear
        cfg_db = '0; cfg_rise_en[1] = 1'b1; cfg_fall_en[1] = 1'b1;
        gpio_i[1] = 1'b1;
        steps(4);
        chk("ch1_rise_irqs", 32'(irq_status[1]), 32'h1);
        cfg_rise_en[1] = 1'b0;
        gpio_i[1] = 1'b0;
        steps(3);
        chk("ch1_fell", 32'(pin_state[1]), 32'h0);
        irq_clr[1] = 1'b1;
        step();
        chk("set_wins", 32'(irq_status[1]), 32'h1);
        step();
        chk("clr_alone", 32'(irq_status[1]), 32'h0);
        irq_clr = '0;

        // 32-channel build, bypassed debounce on the top channel
        g32_in[31] = 1'b1;
        steps(2);
        chk("ch31_c2", 32'(g32_pin[31]), 32'h0);
        step();
        chk("ch31_c3", 32'(g32_pin[31]), 32'h1);
        g32_in[31] = 1'b0;
        steps(3);
        chk("ch31_fall", 32'(g32_pin[31]), 32'h0);

        // reset in the middle of a long debounce
        cfg_db = 16'd100; gpio_i[4] = 1'b1;
        steps(20);
        rst = 1'b1;
        step();
        chk("midrst_pin", 32'(pin_state), 32'h0);
        chk("midrst_irqs", 32'(irq_status), 32'h0);
        chk("midrst_gpio_t", 32'(gpio_t), 32'h3F);
        chk("midrst_g32_pin", g32_pin, 32'h0);
        rst = 1'b0;
        steps(2);

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < c_N; b++)
                if ($urandom_range(5) == 0) gpio_i[b] = ~gpio_i[b];
            if ($urandom_range(60) == 0) cfg_db = 16'($urandom_range(5));
            if ($urandom_range(40) == 0) begin
                cfg_rise_en = 6'($urandom);
                cfg_fall_en = 6'($urandom);
                cfg_dir     = 6'($urandom);
            end
            cfg_out = 6'($urandom);
            irq_clr = ($urandom_range(3) == 0) ? 6'($urandom) : '0;
            rst     = ($urandom_range(400) == 0);
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
